// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU op sequencer: funct codes, FSM states and
// operation record, plus the counter sizing used to time multi-cycle ops.
// Ports: none (package).
package alu_op_sequencer_pkg;

  // R-type funct codes understood by the TotalALU
  localparam logic [5:0] FUNCT_AND  = 6'd36;
  localparam logic [5:0] FUNCT_OR   = 6'd37;
  localparam logic [5:0] FUNCT_ADD  = 6'd32;
  localparam logic [5:0] FUNCT_SUB  = 6'd34;
  localparam logic [5:0] FUNCT_SLT  = 6'd42;
  localparam logic [5:0] FUNCT_SRL  = 6'd2;
  localparam logic [5:0] FUNCT_DIVU = 6'd27;
  localparam logic [5:0] FUNCT_MFHI = 6'd16;
  localparam logic [5:0] FUNCT_MFLO = 6'd18;
  localparam logic [5:0] FUNCT_NOP  = 6'd0;

  localparam int ALU_LAT_DEF    = 1;
  localparam int DIV_CYCLES_DEF = 32;

  // Wide enough to hold the longest op latency (DIVU) without wrapping
  localparam int CNT_W = $clog2(DIV_CYCLES_DEF + 1);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } seqStateT;

  // Operation as presented to the ALU inputs
  typedef struct packed {
    logic [5:0]  signal;
    logic [31:0] a;
    logic [31:0] b;
  } aluOpT;

endpackage

// File: rtl/alu_funct_decode.sv
// Purpose: classify an R-type funct code as legal and/or multi-cycle (DIVU).
// Latency: combinational. Backpressure: none (pure decode).
// Ports: funct (in, 6) -> legal (out), isDiv (out).
module alu_funct_decode
  import alu_op_sequencer_pkg::*;
(
  input  logic [5:0] funct,
  output logic       legal,
  output logic       isDiv
);

  always_comb begin
    legal = 1'b0;
    isDiv = 1'b0;
    case (funct)
      FUNCT_AND, FUNCT_OR, FUNCT_ADD, FUNCT_SUB,
      FUNCT_SLT, FUNCT_SRL, FUNCT_MFHI, FUNCT_MFLO: legal = 1'b1;
      FUNCT_DIVU: begin
        legal = 1'b1;
        isDiv = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Purpose: issue one R-type op at a time to the TotalALU, hold its inputs for
//   the op latency, capture Output and return it on a response channel.
// Latency: response valid ALU_LAT+1 cycles after accept (DIV_CYCLES+1 for
//   DIVU, 1 for illegal funct). Backpressure: one op outstanding; req_ready
//   low from accept until the cycle after the response is taken; RESP holds
//   while rsp_ready=0 with the ALU Signal parked at NOP.
// Ports: clk, reset (async, active-low); req_* request channel (valid/ready,
//   funct, a, b); rsp_* response channel (valid/ready, data, err);
//   alu_dataA/alu_dataB/alu_signal to the ALU, alu_result from it; busy.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int         ALU_LAT    = ALU_LAT_DEF,
  parameter int         DIV_CYCLES = DIV_CYCLES_DEF,
  parameter logic [5:0] NOP_SIGNAL = FUNCT_NOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_funct,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] alu_dataA,
  output logic [31:0] alu_dataB,
  output logic [5:0]  alu_signal,
  input  logic [31:0] alu_result,
  output logic        busy
);

  seqStateT         stateQ, stateD;
  aluOpT            opQ;
  logic [CNT_W-1:0] cntQ;
  logic             divQ;
  logic [31:0]      rspDataQ;
  logic             rspErrQ;

  logic reqLegal, reqIsDiv;
  logic reqFire;
  logic lastExecCycle;

  alu_funct_decode uDecode (
    .funct (req_funct),
    .legal (reqLegal),
    .isDiv (reqIsDiv)
  );

  assign reqFire       = req_valid & req_ready;
  assign lastExecCycle = (stateQ == EXEC) && (cntQ == CNT_W'(1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stateQ <= IDLE;
    else        stateQ <= stateD;
  end

  // Next-state logic
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE: if (reqFire) stateD = reqLegal ? EXEC : RESP;
      EXEC: if (lastExecCycle) stateD = RESP;
      RESP: if (rsp_ready) stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  // Datapath: ALU drive registers, latency counter, response capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opQ.signal <= NOP_SIGNAL;
      opQ.a      <= '0;
      opQ.b      <= '0;
      cntQ       <= '0;
      divQ       <= 1'b0;
      rspDataQ   <= '0;
      rspErrQ    <= 1'b0;
    end else begin
      case (stateQ)
        IDLE: begin
          if (reqFire) begin
            if (reqLegal) begin
              opQ.signal <= req_funct;
              opQ.a      <= req_a;
              opQ.b      <= req_b;
              divQ       <= reqIsDiv;
              cntQ       <= reqIsDiv ? CNT_W'(DIV_CYCLES) : CNT_W'(ALU_LAT);
            end else begin
              // Illegal op never reaches the ALU; answer straight away
              rspDataQ <= '0;
              rspErrQ  <= 1'b1;
            end
          end
        end
        EXEC: begin
          cntQ <= cntQ - CNT_W'(1);
          if (lastExecCycle) begin
            // DIVU's result lives in HiLo; it is read back with MFHI/MFLO
            rspDataQ   <= divQ ? '0 : alu_result;
            rspErrQ    <= 1'b0;
            // Park Signal at NOP so HiLo is left alone while RESP waits
            opQ.signal <= NOP_SIGNAL;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (stateQ == IDLE);
  assign rsp_valid  = (stateQ == RESP);
  assign busy       = (stateQ != IDLE);
  assign rsp_data   = rspDataQ;
  assign rsp_err    = rspErrQ;
  assign alu_dataA  = opQ.a;
  assign alu_dataB  = opQ.b;
  assign alu_signal = opQ.signal;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Issue/collect stage directly upstream of the TotalALU datapath.
- Accepts one R-type operation request at a time (funct code plus two 32-bit operands) over a valid/ready handshake.
- Drives the ALU's dataA/dataB/Signal inputs and holds them stable for the op's full latency, including the multi-cycle DIVU.
- Captures the ALU Output and returns it on a valid/ready response channel; illegal funct codes are rejected without touching the ALU.

Parameters:
- ALU_LAT, 1, cycles from Signal driven to valid ALU Output for AND/OR/ADD/SUB/SLT/SRL/MFHI/MFLO (ALUControl is clocked).
- DIV_CYCLES, 32, cycles DIVU Signal must be held before HiLo holds the quotient/remainder.
- NOP_SIGNAL, 6'b000000, Signal value driven whenever no op is executing.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_funct  in  6  funct code: AND 36, OR 37, ADD 32, SUB 34, SRL 2, SLT 42, DIVU 27, MFHI 16, MFLO 18.
- req_a  in  32  operand A.
- req_b  in  32  operand B.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  32  captured ALU Output; 0 for DIVU and illegal ops.
- rsp_err  out  1  illegal funct.
- alu_dataA  out  32  to ALU dataA.
- alu_dataB  out  32  to ALU dataB.
- alu_signal  out  6  to ALU Signal.
- alu_result  in  32  from ALU Output.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values (async, reset=0): state IDLE; req_ready=1; rsp_valid=0; rsp_data=0; rsp_err=0; alu_dataA=0; alu_dataB=0; alu_signal=NOP_SIGNAL; busy=0; counter=0.
- States:
  - IDLE: req_ready=1. Handshake req_valid&req_ready at an edge latches funct/a/b.
    - Legal funct -> EXEC, with counter loaded to DIV_CYCLES (DIVU) or ALU_LAT (others).
    - Illegal funct -> RESP with rsp_err=1, rsp_data=0.
  - EXEC: req_ready=0. alu_dataA/B/signal hold the latched values every cycle. Counter decrements each cycle.
    - On the cycle counter==1, rsp_data <= alu_result (0 for DIVU), rsp_err <= 0, next state RESP.
  - RESP: rsp_valid=1. rsp_data/rsp_err held stable.
    - alu_signal returns to NOP_SIGNAL on entry; alu_dataA/B keep their last values.
    - rsp_valid&rsp_ready -> IDLE.
- Latency:
  - Accept edge = cycle 0; rsp_valid first high in cycle L+1 (L = ALU_LAT or DIV_CYCLES).
  - ADD with default ALU_LAT: rsp_valid in cycle 2. DIVU: rsp_valid in cycle 33.
- Not pipelined: at most one op outstanding. req_ready is 0 throughout EXEC and RESP.
- Response backpressure: RESP holds indefinitely while rsp_ready=0; ALU inputs stay at NOP so HiLo is undisturbed.
- Request is not accepted in the same cycle a response completes; req_ready rises the cycle after RESP exits.
- MFHI/MFLO are plain ALU_LAT ops; correctness relies on a preceding DIVU having completed. No interlock is needed because ops are serialised.
- Operands pass unmodified; no width extension. Arithmetic is entirely in the ALU.
- Reset mid-operation: immediate return to reset values. Any partial DIVU is abandoned and no response is issued. Divider/HiLo share the reset and clear with it.
- req_funct/req_a/req_b are ignored outside the handshake cycle.

Decomposition:
- Shared package: funct localparams (AND/OR/ADD/SUB/SLT/SRL/DIVU/MFHI/MFLO, NOP), state enum IDLE/EXEC/RESP, counter width = clog2(DIV_CYCLES+1).
- One sub-module, alu_funct_decode (combinational): funct -> legal flag, is_div flag.

Test Plan:
- ADD a=5, b=7 -> alu_signal=32 held 1 cycle; rsp_valid in cycle 2, rsp_data=12, rsp_err=0.
- SUB a=3, b=5 -> rsp_data=0xFFFFFFFE; then SLT a=3, b=5 -> rsp_data=1; req_ready=0 from accept until the response is taken.
- DIVU a=100, b=7 -> alu_signal=27 for exactly 32 cycles, rsp_valid in cycle 33 with rsp_data=0; then MFLO -> 14, MFHI -> 2.
- Illegal funct 6'b000011 -> alu_signal stays 0, rsp_valid the cycle after accept, rsp_err=1, rsp_data=0.
- OR a=0xF0, b=0x0F with rsp_ready=0 for 10 cycles -> rsp_valid/rsp_data=0xFF stable, req_ready=0; release -> IDLE next cycle.
- reset=0 at cycle 10 of a DIVU -> all outputs at reset values immediately; after release, req_ready=1, no stray rsp_valid, new ADD works.
